// File: rtl/lsu_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : lsu_req_queue
// In-order load/store request FIFO feeding a one-access-at-a-time sequencer
// for the data memory strobe/stall port. Optional macro LSU_TIMEOUT_EN adds
// an access-abort timeout.
// Revision : 1.0
// ============================================================================
module lsu_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_sign_mask,
    output logic        resp_valid,
    output logic        resp_is_load,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data,
    input  logic        mem_stall
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_ENT_W = 1 + 4 + 32 + 32;
    localparam logic [C_PTR_W:0] C_FULL = (C_PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [C_ENT_W-1:0] r_fifo [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [C_PTR_W:0]   r_count;
    logic [C_ENT_W-1:0] w_head;
    logic               w_empty, w_full, w_push, w_pop;
    logic               w_strobe, w_capture, w_in_access, w_timeout;
    logic               r_is_load;
    logic [31:0]        r_rdata;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == C_FULL);
    assign req_ready   = !w_full;
    assign w_push      = req_valid && !w_full;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_in_access = (r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {req_write, req_sign_mask, req_wdata, req_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT + 1);
    logic [C_TMO_W-1:0] r_tmo_cnt;
    logic               r_err;

    always_ff @(posedge clk) begin
        if (rst || w_pop)      r_tmo_cnt <= '0;
        else if (w_in_access)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_timeout = w_in_access && (r_tmo_cnt == C_TMO_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || w_pop)   r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
    end

    assign resp_err = (r_state == ST_RESP) && r_err;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_timeout        = 1'b0;
    assign resp_err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // The strobe gates the memory clock, so it must fall in the same cycle
    // mem_stall is first seen low, not one cycle later.
    always_comb begin
        w_state_nxt = r_state;
        w_strobe    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_nxt = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                w_strobe = 1'b1;
                if (w_timeout) begin
                    w_strobe    = 1'b0;
                    w_state_nxt = ST_RESP;
                end else if (mem_stall) begin
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                w_strobe = mem_stall;
                if (w_timeout) begin
                    w_strobe    = 1'b0;
                    w_state_nxt = ST_RESP;
                end else if (!mem_stall) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            r_is_load      <= 1'b0;
            r_rdata        <= '0;
        end else begin
            if (w_pop) begin
                mem_addr       <= w_head[31:0];
                mem_write_data <= w_head[63:32];
                mem_sign_mask  <= w_head[67:64];
                r_is_load      <= !w_head[68];
            end
            if (w_capture)      r_rdata <= r_is_load ? mem_read_data : 32'd0;
            else if (w_timeout) r_rdata <= 32'd0;
        end
    end

    assign mem_read     = r_is_load && w_strobe;
    assign mem_write    = !r_is_load && w_strobe;
    assign resp_valid   = (r_state == ST_RESP);
    assign resp_is_load = (r_state == ST_RESP) && r_is_load;
    assign resp_rdata   = r_rdata;
    assign busy         = !w_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lsu_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_req_queue
// Directed self-checking bench for lsu_req_queue with a strobe/stall memory model.
// Revision : 1.0
// ============================================================================
module tb_lsu_req_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk, rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sign_mask;
    logic        resp_valid, resp_is_load, resp_err, busy;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_read, mem_write, mem_stall;

    lsu_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sign_mask(req_sign_mask),
        .resp_valid(resp_valid), .resp_is_load(resp_is_load),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_sign_mask(mem_sign_mask), .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .mem_stall(mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: stall rises the cycle after the strobe, holds two cycles.
    logic        hang;
    logic [1:0]  m_cnt;
    logic [31:0] rd_base;
    assign mem_read_data = rd_base ^ mem_addr;

    always @(posedge clk) begin
        if (rst) begin
            mem_stall <= 1'b0;
            m_cnt     <= 2'd0;
        end else begin
            case (m_cnt)
                2'd0: if (mem_read || mem_write) begin
                    mem_stall <= 1'b1;
                    m_cnt     <= hang ? 2'd3 : 2'd1;
                end
                2'd1: m_cnt <= 2'd2;
                2'd2: begin mem_stall <= 1'b0; m_cnt <= 2'd0; end
                default: if (!hang) begin mem_stall <= 1'b0; m_cnt <= 2'd0; end
            endcase
        end
    end

    logic        prev_strobe = 1'b0;
    int          q_st[$], q_en[$], q_rc[$];
    logic [31:0] q_rd[$], q_wd[$];
    logic        q_ld[$], q_er[$];
    int          n_rd = 0, n_wr = 0, n_both = 0;

    always @(negedge clk) begin
        if (mem_read && mem_write) n_both++;
        if (mem_read)  n_rd++;
        if (mem_write) n_wr++;
        if ((mem_read || mem_write) && !prev_strobe) begin
            q_st.push_back(cyc);
            if (mem_write) q_wd.push_back(mem_write_data);
        end
        if (!(mem_read || mem_write) && prev_strobe) q_en.push_back(cyc - 1);
        prev_strobe = mem_read || mem_write;
        if (resp_valid) begin
            q_rc.push_back(cyc);
            q_rd.push_back(resp_rdata);
            q_ld.push_back(resp_is_load);
            q_er.push_back(resp_err);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_st.delete(); q_en.delete(); q_rc.delete();
        q_rd.delete(); q_wd.delete(); q_ld.delete(); q_er.delete();
        n_rd = 0; n_wr = 0;
    endtask

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] mask, output int acc);
        int k;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wd; req_sign_mask = mask;
        k = 0;
        while (!req_ready && k < 100) begin
            tick();
            k++;
        end
        chk("req_accept", {31'd0, req_ready}, 32'd1);
        acc = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n, input int budget);
        int k;
        k = 0;
        while (q_rc.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("resp_count", q_rc.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int acc[8];
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_sign_mask = '0; hang = 1'b0; rd_base = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_ctrl", {25'd0, resp_valid, resp_is_load, resp_err, mem_read,
                         mem_write, req_ready, busy}, 32'b10);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_data", mem_write_data ^ resp_rdata ^ {28'd0, mem_sign_mask}, 32'd0);
        rst = 1'b0;
        tick();

        // Single load
        clear_log();
        rd_base = 32'hDEADFEEF;
        send(1'b0, 32'h4000, 32'd0, 4'b0100, t);
        wait_resp(1, 30);
        repeat (4) tick();
        chk("ld_strobe_start", q_st[0], t + 2);
        chk("ld_strobe_end", q_en[0], t + 4);
        chk("ld_accesses", q_st.size(), 1);
        chk("ld_rd_cycles", n_rd, 3);
        chk("ld_wr_cycles", n_wr, 0);
        chk("ld_resp_cycle", q_rc[0], t + 6);
        chk("ld_is_load", {31'd0, q_ld[0]}, 32'd1);
        chk("ld_rdata", q_rd[0], 32'hDEADBEEF);
        chk("ld_addr_mask", {mem_sign_mask, mem_addr[27:0]}, {4'b0100, 28'h4000});

        // Single store
        clear_log();
        send(1'b1, 32'h2000, 32'h000000A5, 4'b0001, t);
        wait_resp(1, 30);
        repeat (4) tick();
        chk("st_strobe_start", q_st[0], t + 2);
        chk("st_strobe_end", q_en[0], t + 4);
        chk("st_wr_cycles", n_wr, 3);
        chk("st_rd_cycles", n_rd, 0);
        chk("st_wdata", q_wd[0], 32'h000000A5);
        chk("st_resp_cycle", q_rc[0], t + 6);
        chk("st_is_load", {31'd0, q_ld[0]}, 32'd0);
        chk("st_rdata", q_rd[0], 32'd0);
        chk("st_mask", {28'd0, mem_sign_mask}, 32'b0001);

        // Five back-to-back loads: queue fills, responses every 6 cycles
        clear_log();
        rd_base = 32'h1234_0000;
        for (int i = 0; i < 5; i++) send(1'b0, 32'h100 + 32'(4 * i), 32'd0, 4'b0010, acc[i]);
        t = acc[0];
        chk("b2b_ready_low", {31'd0, req_ready}, 32'd0);
        for (int i = 1; i < 5; i++) chk("b2b_accept_cycle", acc[i], t + i);
        wait_resp(5, 80);
        for (int i = 0; i < 5; i++) begin
            chk("b2b_resp_cycle", q_rc[i], t + 6 + 6 * i);
            chk("b2b_rdata", q_rd[i], 32'h1234_0000 ^ (32'h100 + 32'(4 * i)));
        end

        // 2*DEPTH mixed requests through a full queue: order and wrap
        clear_log();
        rd_base = 32'h0F0F_0000;
        for (int i = 0; i < 8; i++)
            send(i[0], 32'h800 + 32'(16 * i), 32'h1111_1111 * 32'(i), 4'(i), acc[i]);
        wait_resp(8, 120);
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            chk("wrap_is_load", {31'd0, q_ld[i]}, {31'd0, ~i[0]});
            chk("wrap_rdata", q_rd[i], i[0] ? 32'd0 : (32'h0F0F_0000 ^ (32'h800 + 32'(16 * i))));
        end
        for (int i = 0; i < 4; i++) chk("wrap_wdata", q_wd[i], 32'h1111_1111 * 32'(2 * i + 1));
        chk("wrap_rd_wr_cycles", {n_rd[15:0], n_wr[15:0]}, {16'd12, 16'd12});
        chk("wrap_idle", {30'd0, busy, req_ready}, 32'b01);

        // Reset while in WAIT_LO with two entries queued
        clear_log();
        for (int i = 0; i < 3; i++) send(1'b0, 32'h600 + 32'(4 * i), 32'd0, 4'd0, acc[i]);
        t = acc[0];
        tick();
        chk("rst_mid_cycle", cyc, t + 4);
        chk("rst_mid_strobe", {31'd0, mem_read}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_ctrl", {25'd0, resp_valid, resp_is_load, resp_err, mem_read,
                             mem_write, req_ready, busy}, 32'b10);
        chk("rst_mid_addr", mem_addr, 32'd0);
        rst = 1'b0;
        repeat (15) tick();
        chk("rst_mid_no_resp", q_rc.size(), 0);
        chk("rst_mid_accesses", q_st.size(), 1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);

`ifdef LSU_TIMEOUT_EN
        // Stuck memory: abort after TIMEOUT cycles, next entry proceeds
        clear_log();
        hang = 1'b1;
        rd_base = 32'h5555_0000;
        send(1'b0, 32'h3000, 32'd0, 4'd0, t);
        send(1'b0, 32'h3004, 32'd0, 4'd0, acc[1]);
        wait_resp(1, 40);
        hang = 1'b0;
        chk("tmo_strobe_start", q_st[0], t + 2);
        chk("tmo_strobe_end", q_en[0], t + 9);
        chk("tmo_resp_cycle", q_rc[0], t + 11);
        chk("tmo_err", {31'd0, q_er[0]}, 32'd1);
        chk("tmo_rdata", q_rd[0], 32'd0);
        wait_resp(2, 40);
        chk("tmo_next_start", q_st[1], t + 13);
        chk("tmo_next_resp", q_rc[1], t + 17);
        chk("tmo_next_err", {31'd0, q_er[1]}, 32'd0);
        chk("tmo_next_rdata", q_rd[1], 32'h5555_0000 ^ 32'h3004);
`endif

        chk("never_both_strobes", n_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_req_queue.md
Name: lsu_req_queue

Overview:
- In-order load/store request queue and sequencer sitting directly upstream of the data memory.
- Accepts load/store requests from the pipeline memory stage over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues them one at a time to the data memory strobe/stall interface and returns one response per request.
- Decouples pipeline stalls from the memory's multi-cycle access.

Parameters:
DEPTH, 4, FIFO entries; power of 2, ≥2
TIMEOUT, 64, max cycles in an access before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  queue can accept (= !full)
req_write  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_sign_mask  in  4  [3]=sign-extend, [2:0]=size mask (passed through)
resp_valid  out  1  one-cycle response pulse
resp_is_load  out  1  response belongs to a load
resp_rdata  out  32  load data (0 for stores)
resp_err  out  1  access aborted by timeout
busy  out  1  FIFO non-empty or FSM not IDLE
mem_addr  out  32  to memory
mem_write_data  out  32  to memory
mem_sign_mask  out  4  to memory
mem_read  out  1  load strobe
mem_write  out  1  store strobe
mem_read_data  in  32  from memory
mem_stall  in  1  memory busy flag

Behaviour:
- Clock port clk; reset port rst, synchronous, active-high. Single clock domain.
- Reset: FIFO empty, FSM IDLE; resp_valid, resp_is_load, resp_err, mem_read, mem_write = 0; resp_rdata, mem_addr, mem_write_data, mem_sign_mask = 0; req_ready = 1; busy = 0. A reset mid-access drops all queued and in-flight requests and emits no response.
- FIFO push: req_valid && req_ready at a posedge. No push when full.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - A pushed entry is visible to the FSM the next cycle; there is no fall-through.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the mem_* registers and the op flag, then go to WAIT_HI.
  - WAIT_HI: strobe high; go to WAIT_LO when mem_stall==1.
  - WAIT_LO: strobe = mem_stall, i.e. combinationally low in the cycle mem_stall is first seen 0. In that cycle, capture mem_read_data (loads only) and go to RESP.
  - RESP: resp_valid=1 for exactly one cycle with resp_is_load, resp_rdata, resp_err; then go to IDLE.
- Strobe:
  - mem_read = op_is_load && strobe; mem_write = !op_is_load && strobe.
  - Never both high. Both low in IDLE and RESP.
  - Dropping the strobe combinationally is mandatory: the memory's clock is gated by the strobe, and any strobe still high once it returns to idle starts a duplicate access.
- mem_addr, mem_write_data and mem_sign_mask are held stable from WAIT_HI entry until the next IDLE pop.
- Latency: request accepted at cycle t → strobe high at t+2 → mem_stall high at t+3 → mem_stall low at t+5 → resp_valid at t+6. Same timing for loads and stores.
- Back-to-back: the next strobe rises 2 cycles after RESP (RESP → IDLE pop → WAIT_HI). Throughput is one access per 6 cycles.
- There is no response backpressure; the consumer must take resp_valid when it is asserted.
- Ordering: strictly FIFO. Responses arrive in request order.

Optional Feature:
LSU_TIMEOUT_EN
- With the macro defined: a cycle counter clears on WAIT_HI entry and increments in WAIT_HI and WAIT_LO.
  - Reaching TIMEOUT forces strobe low and moves to RESP with resp_err=1 and resp_rdata=0.
  - The queue then continues with the next entry.
- Without the macro: no counter, and resp_err is tied to 0. The FSM waits indefinitely.

Test Plan:
- Reset, then one load at addr 0x4000, sign_mask 4'b0100; memory model returns 0xDEADBEEF → mem_read high for exactly cycles t+2..t+4, resp_valid at t+6, resp_is_load=1, resp_rdata=0xDEADBEEF, exactly one memory access.
- Store 0x000000A5 to 0x2000, sign_mask 4'b0001 → mem_write high t+2..t+4, mem_write_data=0x000000A5, resp_valid at t+6 with resp_is_load=0 and resp_rdata=0.
- Push 5 requests back-to-back with DEPTH=4 → req_ready low after 4 occupy the queue. The 5th is accepted when the first pop frees a slot. 5 responses arrive in order, each 6 cycles apart.
- Push on the same cycle as IDLE pops with FIFO full → count is unchanged, no entry lost or duplicated, pointers wrap correctly after 2×DEPTH requests.
- Assert rst while in WAIT_LO with 2 entries queued → next cycle all outputs are at reset values, no resp_valid, busy=0.
- With LSU_TIMEOUT_EN and TIMEOUT=8, memory holds mem_stall=1 forever → strobe drops after 8 cycles, resp_valid with resp_err=1 and resp_rdata=0, and the next queued request then issues normally.
